// File: rtl/ceespu_branch_resolve.sv
// In-order branch resolution queue: records predicted branches from fetch, checks
// them against execute outcomes, drives predictor updates and mispredict redirects.
module ceespu_branch_resolve #(
    parameter int DEPTH_LOG2 = 2,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [1:0]        push_state,
    input  logic              push_pred,
    input  logic [ADDR_W-1:0] push_alt_pc,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    output logic              full,
    output logic              empty,
    output logic              update_table,
    output logic [ADDR_W-1:0] branch_address,
    output logic [1:0]        branch_prediction_state,
    output logic              branch_taken,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              error
);

    localparam int ENTRY_W = 2 * ADDR_W + 3;
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [ENTRY_W-1:0]    mem_q [DEPTH];

    logic              update_table_q, update_table_d;
    logic [ADDR_W-1:0] branch_address_q, branch_address_d;
    logic [1:0]        branch_state_q, branch_state_d;
    logic              branch_taken_q, branch_taken_d;
    logic              mispredict_q, mispredict_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;
    logic              error_q, error_d;

    logic [ADDR_W-1:0] head_pc;
    logic [1:0]        head_state;
    logic              head_pred;
    logic [ADDR_W-1:0] head_alt_pc;
    logic              pop;
    logic              mis;
    logic              push_acc;

    assign {head_pc, head_state, head_pred, head_alt_pc} = mem_q[rd_ptr_q];

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);

    always_comb begin
        pop      = resolve_valid & ~empty;
        mis      = pop & (head_pred != resolve_taken);
        // A push beside a mispredicting pop is on the wrong path and is dropped.
        push_acc = push & (state_q == RUN) & ~mis & (~full | pop);

        state_d  = (state_q == FLUSH) ? RUN : state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (mis) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            wr_ptr_d = rd_ptr_q + PTR_ONE;
            count_d  = '0;
            state_d  = FLUSH;
        end else begin
            if (pop)      rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d = count_q + {{DEPTH_LOG2{1'b0}}, push_acc}
                              - {{DEPTH_LOG2{1'b0}}, pop};
        end

        error_d = error_q
                | (resolve_valid & empty)
                | (push & full & ~pop & (state_q == RUN));

        update_table_d   = pop;
        mispredict_d     = mis;
        branch_address_d = branch_address_q;
        branch_state_d   = branch_state_q;
        branch_taken_d   = branch_taken_q;
        redirect_pc_d    = redirect_pc_q;
        if (pop) begin
            branch_address_d = head_pc;
            branch_state_d   = head_state;
            branch_taken_d   = resolve_taken;
            redirect_pc_d    = head_alt_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= RUN;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            update_table_q   <= 1'b0;
            branch_address_q <= '0;
            branch_state_q   <= '0;
            branch_taken_q   <= 1'b0;
            mispredict_q     <= 1'b0;
            redirect_pc_q    <= '0;
            error_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            update_table_q   <= update_table_d;
            branch_address_q <= branch_address_d;
            branch_state_q   <= branch_state_d;
            branch_taken_q   <= branch_taken_d;
            mispredict_q     <= mispredict_d;
            redirect_pc_q    <= redirect_pc_d;
            error_q          <= error_d;
        end
    end

    // Queue storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= {push_pc, push_state, push_pred, push_alt_pc};
        end
    end

    assign update_table            = update_table_q;
    assign branch_address          = branch_address_q;
    assign branch_prediction_state = branch_state_q;
    assign branch_taken            = branch_taken_q;
    assign mispredict              = mispredict_q;
    assign redirect_pc             = redirect_pc_q;
    assign error                   = error_q;

endmodule

// File: tb/tb_ceespu_branch_resolve.sv
// Directed bench for ceespu_branch_resolve with hand-computed expectations.
module tb_ceespu_branch_resolve;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push;
    logic [15:0] push_pc;
    logic [1:0]  push_state;
    logic        push_pred;
    logic [15:0] push_alt_pc;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        full;
    logic        empty;
    logic        update_table;
    logic [15:0] branch_address;
    logic [1:0]  branch_prediction_state;
    logic        branch_taken;
    logic        mispredict;
    logic [15:0] redirect_pc;
    logic        error;

    int n_checks = 0;
    int n_errors = 0;

    ceespu_branch_resolve #(.DEPTH_LOG2(2), .ADDR_W(16)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .push                    (push),
        .push_pc                 (push_pc),
        .push_state              (push_state),
        .push_pred               (push_pred),
        .push_alt_pc             (push_alt_pc),
        .resolve_valid           (resolve_valid),
        .resolve_taken           (resolve_taken),
        .full                    (full),
        .empty                   (empty),
        .update_table            (update_table),
        .branch_address          (branch_address),
        .branch_prediction_state (branch_prediction_state),
        .branch_taken            (branch_taken),
        .mispredict              (mispredict),
        .redirect_pc             (redirect_pc),
        .error                   (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic p, input logic [15:0] pc, input logic [1:0] st,
                         input logic pr, input logic [15:0] alt,
                         input logic rv, input logic rt);
        push          = p;
        push_pc       = pc;
        push_state    = st;
        push_pred     = pr;
        push_alt_pc   = alt;
        resolve_valid = rv;
        resolve_taken = rt;
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #1;
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_upd", 32'(update_table), 32'h0);
        chk("rst_err", 32'(error), 32'h0);
        #12;
        rst_n = 1'b1;
        step();

        // Correct prediction
        drive(1'b1, 16'h0040, 2'd3, 1'b1, 16'h0044, 1'b0, 1'b0);
        step();
        chk("t2_notempty", 32'(empty), 32'h0);
        drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 1'b1, 1'b1);
        step();
        chk("t2_upd", 32'(update_table), 32'h1);
        chk("t2_addr", 32'(branch_address), 32'h0040);
        chk("t2_state", 32'(branch_prediction_state), 32'h3);
        chk("t2_taken", 32'(branch_taken), 32'h1);
        chk("t2_mis", 32'(mispredict), 32'h0);
        chk("t2_empty", 32'(empty), 32'h1);
        idle();
        step();
        chk("t2_upd_off", 32'(update_table), 32'h0);
        chk("t2_addr_hold", 32'(branch_address), 32'h0040);

        // Mispredict flush
        drive(1'b1, 16'h0010, 2'd1, 1'b0, 16'h0080, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h0014, 2'd2, 1'b1, 16'h0050, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h0018, 2'd2, 1'b1, 16'h0060, 1'b0, 1'b0);
        step();
        drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 1'b1, 1'b1);
        step();
        chk("t3_mis", 32'(mispredict), 32'h1);
        chk("t3_redirect", 32'(redirect_pc), 32'h0080);
        chk("t3_addr", 32'(branch_address), 32'h0010);
        chk("t3_empty", 32'(empty), 32'h1);
        drive(1'b1, 16'h0099, 2'd1, 1'b1, 16'h009c, 1'b0, 1'b0);
        step();
        chk("t3_flush_push_ignored", 32'(empty), 32'h1);
        chk("t3_mis_pulse", 32'(mispredict), 32'h0);
        chk("t3_no_err", 32'(error), 32'h0);
        drive(1'b1, 16'h0020, 2'd2, 1'b1, 16'h0024, 1'b0, 1'b0);
        step();
        chk("t3_push_after", 32'(empty), 32'h0);
        drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 1'b1, 1'b1);
        step();
        chk("t3_addr2", 32'(branch_address), 32'h0020);
        chk("t3_state2", 32'(branch_prediction_state), 32'h2);
        chk("t3_mis2", 32'(mispredict), 32'h0);
        chk("t3_empty2", 32'(empty), 32'h1);

        // Resolve on empty
        drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 1'b1, 1'b0);
        step();
        chk("t6_no_upd", 32'(update_table), 32'h0);
        chk("t6_err", 32'(error), 32'h1);
        idle();
        step();
        step();
        chk("t6_err_sticky", 32'(error), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t6_err_rst", 32'(error), 32'h0);
        rst_n = 1'b1;
        step();

        // Full, overflow and wrap
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'(16'h0100 + 4 * i), 2'd3, 1'b1, 16'h0000, 1'b0, 1'b0);
            step();
        end
        chk("t4_full", 32'(full), 32'h1);
        chk("t4_err_before", 32'(error), 32'h0);
        drive(1'b1, 16'h01f0, 2'd3, 1'b1, 16'h0000, 1'b0, 1'b0);
        step();
        chk("t4_overflow_err", 32'(error), 32'h1);
        chk("t4_still_full", 32'(full), 32'h1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 1'b1, 1'b1);
            step();
            chk("t4_pop_addr", 32'(branch_address), 32'(16'h0100 + 4 * i));
            drive(1'b1, 16'(16'h0110 + 4 * i), 2'd1, 1'b1, 16'h0000, 1'b0, 1'b0);
            step();
            chk("t4_refull", 32'(full), 32'h1);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 1'b1, 1'b1);
            step();
            chk("t4_drain_addr", 32'(branch_address), 32'(16'h0110 + 4 * i));
        end
        chk("t4_drained", 32'(empty), 32'h1);

        // Simultaneous push and pop at full
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'(16'h0200 + 4 * i), 2'd2, 1'b1, 16'h0000, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 16'h0300, 2'd1, 1'b1, 16'h0000, 1'b1, 1'b1);
        step();
        chk("t5_full_kept", 32'(full), 32'h1);
        chk("t5_addr0", 32'(branch_address), 32'h0200);
        chk("t5_mis", 32'(mispredict), 32'h0);
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 1'b1, 1'b1);
            step();
            chk("t5_addr", 32'(branch_address), 32'(16'h0200 + 4 * i));
        end
        drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 1'b1, 1'b1);
        step();
        chk("t5_pushed_out", 32'(branch_address), 32'h0300);
        chk("t5_pushed_state", 32'(branch_prediction_state), 32'h1);
        chk("t5_empty", 32'(empty), 32'h1);

        // Reset mid-run with three entries queued
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(16'h0400 + 4 * i), 2'd3, 1'b1, 16'h0000, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 1'b1, 1'b1);
        step();
        chk("t1_pre_addr", 32'(branch_address), 32'h0400);
        chk("t1_pre_err", 32'(error), 32'h1);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_empty", 32'(empty), 32'h1);
        chk("t1_full", 32'(full), 32'h0);
        chk("t1_addr", 32'(branch_address), 32'h0);
        chk("t1_err", 32'(error), 32'h0);
        chk("t1_state", 32'(branch_prediction_state), 32'h0);
        chk("t1_taken", 32'(branch_taken), 32'h0);
        chk("t1_upd", 32'(update_table), 32'h0);
        #20;
        rst_n = 1'b1;
        step();
        chk("t1_after_empty", 32'(empty), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
